// File: rtl/riscv_exu_ctrl_dmem.sv
// Execute/memory slice of the 16-bit single-cycle core: opcode decoder, ALU and a
// small data RAM with asynchronous clear, synchronous write and combinational read.
module riscv_exu_ctrl_dmem #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        alu_ctrl,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    input  logic [3:0]        opcode,
    output logic [1:0]        alu_op,
    output logic              jump,
    output logic              beq,
    output logic              bne,
    output logic              mem_read,
    output logic              mem_write,
    output logic              alu_src,
    output logic              reg_dst,
    output logic              mem_to_reg,
    output logic              reg_write,
    input  logic [DATA_W-1:0] mem_access_addr,
    input  logic [DATA_W-1:0] mem_write_data,
    input  logic              mem_write_en,
    input  logic              mem_read_en,
    output logic [DATA_W-1:0] mem_read_data
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_NOT = 3'b010;
    localparam logic [2:0] ALU_SHL = 3'b011;
    localparam logic [2:0] ALU_SHR = 3'b100;
    localparam logic [2:0] ALU_AND = 3'b101;
    localparam logic [2:0] ALU_OR  = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Shift amounts use the whole b operand, so any b >= DATA_W yields zero.
    always_comb begin
        result = '0;
        case (alu_ctrl)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_NOT: result = ~a;
            ALU_SHL: result = a << b;
            ALU_SHR: result = a >> b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLT: result = {{(DATA_W-1){1'b0}}, (a < b)};
            default: result = '0;
        endcase
    end

    assign zero = ~|result;

    always_comb begin
        alu_op     = 2'b00;
        jump       = 1'b0;
        beq        = 1'b0;
        bne        = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        alu_src    = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        case (opcode)
            4'h0: begin
                alu_src    = 1'b1;
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                mem_read   = 1'b1;
                alu_op     = 2'b10;
            end
            4'h1: begin
                alu_src   = 1'b1;
                mem_write = 1'b1;
                alu_op    = 2'b10;
            end
            4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                alu_op    = 2'b00;
            end
            4'hB: begin
                beq    = 1'b1;
                alu_op = 2'b01;
            end
            4'hC: begin
                bne    = 1'b1;
                alu_op = 2'b01;
            end
            4'hD: jump = 1'b1;
            default: ;
        endcase
    end

    logic [AW-1:0]     idx;
    logic              unused_addr_hi;
    logic [DATA_W-1:0] ram_q [DEPTH];
    logic [DATA_W-1:0] ram_d [DEPTH];

    // Upper address bits alias onto the low index on purpose.
    assign idx            = mem_access_addr[AW-1:0];
    assign unused_addr_hi = ^mem_access_addr[DATA_W-1:AW];

    always_comb begin
        ram_d = ram_q;
        if (mem_write_en) begin
            ram_d[idx] = mem_write_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ram_q[i] <= '0;
            end
        end else begin
            ram_q <= ram_d;
        end
    end

    assign mem_read_data = mem_read_en ? ram_q[idx] : '0;

endmodule

// File: tb/tb_riscv_exu_ctrl_dmem.sv
// Directed self-checking bench for the decoder, ALU and data RAM slice.
module tb_riscv_exu_ctrl_dmem;

    logic        clk;
    logic        rst_n;
    logic [15:0] a, b;
    logic [2:0]  alu_ctrl;
    logic [15:0] result;
    logic        zero;
    logic [3:0]  opcode;
    logic [1:0]  alu_op;
    logic        jump, beq, bne, mem_read, mem_write;
    logic        alu_src, reg_dst, mem_to_reg, reg_write;
    logic [15:0] mem_access_addr, mem_write_data, mem_read_data;
    logic        mem_write_en, mem_read_en;

    int total = 0;
    int bad   = 0;

    riscv_exu_ctrl_dmem #(.DATA_W(16), .DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .a(a), .b(b), .alu_ctrl(alu_ctrl), .result(result), .zero(zero),
        .opcode(opcode), .alu_op(alu_op), .jump(jump), .beq(beq), .bne(bne),
        .mem_read(mem_read), .mem_write(mem_write), .alu_src(alu_src),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .mem_access_addr(mem_access_addr), .mem_write_data(mem_write_data),
        .mem_write_en(mem_write_en), .mem_read_en(mem_read_en),
        .mem_read_data(mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic ram_write(input logic [15:0] addr, input logic [15:0] data);
        @(negedge clk);
        mem_access_addr = addr;
        mem_write_data  = data;
        mem_write_en    = 1'b1;
        @(posedge clk);
        #1;
        mem_write_en    = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 8; i++) begin
            mem_access_addr = 16'(i);
            mem_read_en     = 1'b1;
            #1;
            total++;
            if (mem_read_data !== 16'h0000) begin
                bad++;
                $display("FAIL reset_word%0d actual=%h required=0000", i, mem_read_data);
            end
        end
        total++;
        if (result !== 16'h0000 || zero !== 1'b1) begin
            bad++;
            $display("FAIL reset_alu actual=%h/%b required=0000/1", result, zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_alu();
        logic [15:0] exp_r [8];
        logic        exp_z [8];
        exp_r = '{16'd12, 16'd2, 16'hFFF8, 16'd224, 16'd0, 16'd5, 16'd7, 16'd0};
        exp_z = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        a = 16'd7;
        b = 16'd5;
        for (int i = 0; i < 8; i++) begin
            alu_ctrl = 3'(i);
            #1;
            total++;
            if (result !== exp_r[i] || zero !== exp_z[i]) begin
                bad++;
                $display("FAIL alu_ctrl%0d actual=%h/%b required=%h/%b", i, result, zero, exp_r[i], exp_z[i]);
            end
        end
        a = 16'd5; b = 16'd5; alu_ctrl = 3'b001; #1;
        total++;
        if (result !== 16'h0000 || zero !== 1'b1) begin
            bad++;
            $display("FAIL alu_sub_eq actual=%h/%b required=0000/1", result, zero);
        end
    endtask

    task automatic test_alu_edges();
        a = 16'hFFFF; b = 16'h0001; alu_ctrl = 3'b000; #1;
        total++;
        if (result !== 16'h0000 || zero !== 1'b1) begin
            bad++;
            $display("FAIL alu_add_wrap actual=%h/%b required=0000/1", result, zero);
        end
        a = 16'h0000; b = 16'h0001; alu_ctrl = 3'b001; #1;
        total++;
        if (result !== 16'hFFFF || zero !== 1'b0) begin
            bad++;
            $display("FAIL alu_sub_wrap actual=%h/%b required=ffff/0", result, zero);
        end
        a = 16'h0001; b = 16'd16; alu_ctrl = 3'b011; #1;
        total++;
        if (result !== 16'h0000 || zero !== 1'b1) begin
            bad++;
            $display("FAIL alu_shl16 actual=%h/%b required=0000/1", result, zero);
        end
        a = 16'h8000; b = 16'd15; alu_ctrl = 3'b100; #1;
        total++;
        if (result !== 16'h0001) begin
            bad++;
            $display("FAIL alu_shr15 actual=%h required=0001", result);
        end
        a = 16'd2; b = 16'd3; alu_ctrl = 3'b111; #1;
        total++;
        if (result !== 16'h0001 || zero !== 1'b0) begin
            bad++;
            $display("FAIL alu_slt actual=%h/%b required=0001/0", result, zero);
        end
        a = 16'hFFFF; b = 16'h0001; alu_ctrl = 3'b111; #1;
        total++;
        if (result !== 16'h0000) begin
            bad++;
            $display("FAIL alu_slt_unsigned actual=%h required=0000", result);
        end
    endtask

    task automatic test_decoder();
        // {alu_op, jump, beq, bne, mem_read, mem_write, alu_src, reg_dst, mem_to_reg, reg_write}
        logic [10:0] tbl [16];
        logic [10:0] got;
        tbl[0]  = 11'b10_0_0_0_1_0_1_0_1_1;
        tbl[1]  = 11'b10_0_0_0_0_1_1_0_0_0;
        for (int i = 2; i <= 10; i++) tbl[i] = 11'b00_0_0_0_0_0_0_1_0_1;
        tbl[11] = 11'b01_0_1_0_0_0_0_0_0_0;
        tbl[12] = 11'b01_0_0_1_0_0_0_0_0_0;
        tbl[13] = 11'b00_1_0_0_0_0_0_0_0_0;
        tbl[14] = 11'b00_0_0_0_0_0_0_0_0_0;
        tbl[15] = 11'b00_0_0_0_0_0_0_0_0_0;
        for (int i = 0; i < 16; i++) begin
            opcode = 4'(i);
            #1;
            got = {alu_op, jump, beq, bne, mem_read, mem_write, alu_src, reg_dst, mem_to_reg, reg_write};
            total++;
            if (got !== tbl[i]) begin
                bad++;
                $display("FAIL decode_op%0d actual=%b required=%b", i, got, tbl[i]);
            end
        end
    endtask

    task automatic test_ram_basic();
        ram_write(16'd3, 16'h1234);
        mem_access_addr = 16'd3; mem_read_en = 1'b1; #1;
        total++;
        if (mem_read_data !== 16'h1234) begin
            bad++;
            $display("FAIL ram_rd3 actual=%h required=1234", mem_read_data);
        end
        mem_read_en = 1'b0; #1;
        total++;
        if (mem_read_data !== 16'h0000) begin
            bad++;
            $display("FAIL ram_rd_disabled actual=%h required=0000", mem_read_data);
        end
        ram_write(16'd11, 16'h5678);
        mem_access_addr = 16'd3; mem_read_en = 1'b1; #1;
        total++;
        if (mem_read_data !== 16'h5678) begin
            bad++;
            $display("FAIL ram_alias11 actual=%h required=5678", mem_read_data);
        end
        ram_write(16'd7, 16'hA5A5);
        mem_access_addr = 16'hFFFF; #1;
        total++;
        if (mem_read_data !== 16'hA5A5) begin
            bad++;
            $display("FAIL ram_aliasffff actual=%h required=a5a5", mem_read_data);
        end
    endtask

    task automatic test_same_edge();
        ram_write(16'd5, 16'h1111);
        @(negedge clk);
        mem_access_addr = 16'd5;
        mem_write_data  = 16'hBEEF;
        mem_write_en    = 1'b1;
        mem_read_en     = 1'b1;
        #1;
        total++;
        if (mem_read_data !== 16'h1111) begin
            bad++;
            $display("FAIL same_edge_before actual=%h required=1111", mem_read_data);
        end
        @(posedge clk);
        #1;
        mem_write_en = 1'b0;
        total++;
        if (mem_read_data !== 16'hBEEF) begin
            bad++;
            $display("FAIL same_edge_after actual=%h required=beef", mem_read_data);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            mem_access_addr = 16'(i);
            mem_write_data  = 16'(16'h0100 + i * 3);
            mem_write_en    = 1'b1;
            @(negedge clk);
        end
        mem_write_en = 1'b0;
        mem_read_en  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            mem_access_addr = 16'(i);
            #1;
            total++;
            if (mem_read_data !== 16'(16'h0100 + i * 3)) begin
                bad++;
                $display("FAIL b2b_word%0d actual=%h required=%h", i, mem_read_data, 16'(16'h0100 + i * 3));
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 8; i++) ram_write(16'(i), 16'(16'hC000 | i));
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        mem_read_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            mem_access_addr = 16'(i);
            #0.5;
            total++;
            if (mem_read_data !== 16'h0000) begin
                bad++;
                $display("FAIL midreset_word%0d actual=%h required=0000", i, mem_read_data);
            end
        end
        mem_access_addr = 16'd2;
        mem_write_data  = 16'hDEAD;
        mem_write_en    = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (mem_read_data !== 16'h0000) begin
            bad++;
            $display("FAIL write_in_reset actual=%h required=0000", mem_read_data);
        end
        mem_write_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (mem_read_data !== 16'h0000) begin
            bad++;
            $display("FAIL after_reset_word2 actual=%h required=0000", mem_read_data);
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        a               = '0;
        b               = '0;
        alu_ctrl        = 3'b000;
        opcode          = 4'hF;
        mem_access_addr = '0;
        mem_write_data  = '0;
        mem_write_en    = 1'b0;
        mem_read_en     = 1'b0;
        #12;
        test_reset();
        test_alu();
        test_alu_edges();
        test_decoder();
        test_ram_basic();
        test_same_edge();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
